// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble insertion, branch flush and data-memory freeze
// control for the 5-stage core, with a memory-timeout watchdog and
// stall/flush performance counters.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | no outstanding memory wait; pipeline free to advance
// WAIT   | data access pending and not ready; wcnt counts waited cycles
// ERROR  | memory timed out; pipeline frozen and mem_err held until reset
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic mem_req;
  logic freeze;
  logic load_use;

  // Hazard conditions; x0 is never a real producer so it cannot cause a stall.
  always_comb begin
    mem_req  = EX_MEM_MemRead | EX_MEM_MemWrite;
    freeze   = (mem_req & ~dmem_ready) | (state_q == ST_ERROR);
    load_use = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
               ((IF_ID_use_rs1 & (ID_EX_rd == IF_ID_rs1)) |
                (IF_ID_use_rs2 & (ID_EX_rd == IF_ID_rs2)));
  end

  // Pipeline control, priority freeze > branch > load_use > normal.
  // A branch seen during a freeze needs no storage: EX is held, so
  // branch_taken is still high on the release cycle and flushes then.
  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_write  = 1'b1;
    MEM_WB_bubble = 1'b0;
    if (freeze) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  // Memory-wait state machine and timeout watchdog.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !dmem_ready) begin
          state_d = ST_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      ST_WAIT: begin
        if (dmem_ready || !mem_req) begin
          state_d = ST_RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == TIMEOUT_CNT) begin
          state_d = ST_ERROR;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = 16'd0;
      end
    endcase
  end

  // Performance counters; both wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!PC_write) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (IF_ID_flush) begin
      flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      wcnt_q         <= 16'd0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mem_err      = (state_q == ST_ERROR);
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (timeout 64 and 4) share the
// same stimulus; expected control vectors are queued per cycle and checked.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, id_rd;
  logic       use1, use2, id_mr, br, ex_mr, ex_mw, rdy;

  logic        pcw64, ifw64, iff64, idw64, idf64, exw64, bub64, err64;
  logic        pcw4, ifw4, iff4, idw4, idf4, exw4, bub4, err4;
  logic [31:0] stall64, flush64, stall4, flush4;

  hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
    .ID_EX_MemRead(id_mr), .ID_EX_rd(id_rd),
    .branch_taken(br),
    .EX_MEM_MemRead(ex_mr), .EX_MEM_MemWrite(ex_mw),
    .dmem_ready(rdy),
    .PC_write(pcw64), .IF_ID_write(ifw64), .IF_ID_flush(iff64),
    .ID_EX_write(idw64), .ID_EX_flush(idf64), .EX_MEM_write(exw64),
    .MEM_WB_bubble(bub64), .mem_err(err64),
    .stall_cycles(stall64), .flush_events(flush64)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
    .ID_EX_MemRead(id_mr), .ID_EX_rd(id_rd),
    .branch_taken(br),
    .EX_MEM_MemRead(ex_mr), .EX_MEM_MemWrite(ex_mw),
    .dmem_ready(rdy),
    .PC_write(pcw4), .IF_ID_write(ifw4), .IF_ID_flush(iff4),
    .ID_EX_write(idw4), .ID_EX_flush(idf4), .EX_MEM_write(exw4),
    .MEM_WB_bubble(bub4), .mem_err(err4),
    .stall_cycles(stall4), .flush_events(flush4)
  );

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_bubble}
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;

  typedef struct {
    string      tag;
    logic [6:0] ctrl64;
    logic [6:0] ctrl4;
    logic       err64;
    logic       err4;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] es64, ef64, es4, ef4;

  wire [6:0] ctrl64 = {pcw64, ifw64, iff64, idw64, idf64, exw64, bub64};
  wire [6:0] ctrl4  = {pcw4, ifw4, iff4, idw4, idf4, exw4, bub4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                        input logic u2, input logic imr, input logic [4:0] ird,
                        input logic b, input logic emr, input logic emw, input logic r);
    rs1 = a1; rs2 = a2; use1 = u1; use2 = u2; id_mr = imr; id_rd = ird;
    br = b; ex_mr = emr; ex_mw = emw; rdy = r;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One clock cycle with inputs already driven: queue the expectation,
  // compare on the falling edge, then advance the counter model.
  task automatic cyc(input string tag, input logic [6:0] e64, input logic [6:0] e4,
                     input logic r64, input logic r4);
    exp_t e;
    e.tag = tag; e.ctrl64 = e64; e.ctrl4 = e4; e.err64 = r64; e.err4 = r4;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "/ctrl64"}, 32'(ctrl64), 32'(e.ctrl64));
    check({e.tag, "/ctrl4"}, 32'(ctrl4), 32'(e.ctrl4));
    check({e.tag, "/err64"}, 32'(err64), 32'(e.err64));
    check({e.tag, "/err4"}, 32'(err4), 32'(e.err4));
    check({e.tag, "/stall64"}, stall64, es64);
    check({e.tag, "/flush64"}, flush64, ef64);
    check({e.tag, "/stall4"}, stall4, es4);
    check({e.tag, "/flush4"}, flush4, ef4);
    if (!e.ctrl64[6]) es64 = es64 + 32'd1;
    if (e.ctrl64[4])  ef64 = ef64 + 32'd1;
    if (!e.ctrl4[6])  es4 = es4 + 32'd1;
    if (e.ctrl4[4])   ef4 = ef4 + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input string tag, input logic [6:0] e, input logic r);
    cyc(tag, e, e, r, r);
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst_n = 1'b0;
    #1;
    check({tag, "/rst_ctrl64"}, 32'(ctrl64), 32'(C_NORMAL));
    check({tag, "/rst_ctrl4"}, 32'(ctrl4), 32'(C_NORMAL));
    check({tag, "/rst_err64"}, 32'(err64), 32'd0);
    check({tag, "/rst_err4"}, 32'(err4), 32'd0);
    check({tag, "/rst_stall64"}, stall64, 32'd0);
    check({tag, "/rst_flush64"}, flush64, 32'd0);
    check({tag, "/rst_stall4"}, stall4, 32'd0);
    check({tag, "/rst_flush4"}, flush4, 32'd0);
    es64 = '0; ef64 = '0; es4 = '0; ef4 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    es64 = '0; ef64 = '0; es4 = '0; ef4 = '0;
    #2;
    do_reset("por");
    cyc2("idle", C_NORMAL, 1'b0);

    // lw x5 ; add x6,x5,x1 -> one bubble, then the load is in MEM
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc2("lduse_rs1", C_LDUSE, 1'b0);
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc2("lduse_after", C_NORMAL, 1'b0);

    // x0 destination and unused rs2 never stall; used rs2 does
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc2("x0_rd", C_NORMAL, 1'b0);
    set_in(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc2("rs2_unused", C_NORMAL, 1'b0);
    set_in(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc2("lduse_rs2", C_LDUSE, 1'b0);
    set_in(5'd7, 5'd3, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc2("rs1_unused", C_NORMAL, 1'b0);

    // branch flush, then branch together with load-use
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc2("branch", C_BRANCH, 1'b0);
    idle();
    cyc2("post_branch", C_NORMAL, 1'b0);
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc2("branch_lduse", C_BRANCH, 1'b0);
    idle();
    cyc2("post_bl", C_NORMAL, 1'b0);

    // three-cycle memory wait, advance on the fourth
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cyc2($sformatf("mwait%0d", i), C_FREEZE, 1'b0);
    rdy = 1'b1;
    cyc2("mwait_release", C_NORMAL, 1'b0);
    idle();
    cyc2("mwait_idle", C_NORMAL, 1'b0);

    // branch held through a store wait: single flush on release
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) cyc2($sformatf("bwait%0d", i), C_FREEZE, 1'b0);
    rdy = 1'b1;
    cyc2("bwait_release", C_BRANCH, 1'b0);
    idle();
    cyc2("bwait_idle", C_NORMAL, 1'b0);

    // timeout of the MEM_TIMEOUT=4 instance after 5 not-ready cycles
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++)
      cyc($sformatf("to4_%0d", i), C_FREEZE, C_FREEZE, 1'b0, (i >= 6));
    rdy = 1'b1;
    cyc("to4_rdy", C_NORMAL, C_FREEZE, 1'b0, 1'b1);
    idle();
    cyc("to4_idle", C_NORMAL, C_FREEZE, 1'b0, 1'b1);
    br = 1'b1;
    cyc("to4_branch", C_BRANCH, C_FREEZE, 1'b0, 1'b1);
    do_reset("rst_err");
    cyc2("after_rst_err", C_NORMAL, 1'b0);

    // reset in the middle of a wait
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc2("midwait1", C_FREEZE, 1'b0);
    cyc2("midwait2", C_FREEZE, 1'b0);
    do_reset("rst_wait");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc2("after_rst_wait", C_NORMAL, 1'b0);

    // full timeout of the MEM_TIMEOUT=64 instance: 65 not-ready cycles
    rdy = 1'b0;
    for (int i = 1; i <= 66; i++)
      cyc($sformatf("to64_%0d", i), C_FREEZE, C_FREEZE, (i >= 66), (i >= 6));
    rdy = 1'b1;
    cyc2("to64_rdy", C_FREEZE, 1'b1);
    do_reset("final");
    cyc2("final_idle", C_NORMAL, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core; it covers the hazards that EX-stage operand forwarding cannot resolve. It sits beside the ID stage and drives the pipeline-register enables and flushes. Its three jobs:
- Detect load-use dependencies and insert a bubble.
- Flush wrong-path instructions on a taken branch or jump.
- Freeze the pipeline while the data-memory port is not ready, with a timeout watchdog and stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64: consecutive not-ready cycles that trigger `mem_err`; legal range 1..65535.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID
- IF_ID_use_rs1, IF_ID_use_rs2  in  1 each  the instruction in ID actually reads that source
- ID_EX_MemRead  in  1  the instruction in EX is a load
- ID_EX_rd  in  5  destination of the instruction in EX
- branch_taken  in  1  EX resolved a taken branch or jump this cycle
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each  the instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- PC_write  out  1  PC register enable
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  load a NOP into IF/ID
- ID_EX_write  out  1  ID/EX register enable
- ID_EX_flush  out  1  zero the ID/EX control bits (bubble)
- EX_MEM_write  out  1  EX/MEM register enable
- MEM_WB_bubble  out  1  load MEM/WB with RegWrite=0
- mem_err  out  1  sticky data-memory timeout flag
- stall_cycles  out  CNT_W  cycles with PC_write=0
- flush_events  out  CNT_W  number of branch flushes applied

## Operation
Internal signals:
- freeze = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready, or state == ERROR.
- load_use = ID_EX_MemRead & ID_EX_rd != 0 & ((IF_ID_use_rs1 & ID_EX_rd == IF_ID_rs1) | (IF_ID_use_rs2 & ID_EX_rd == IF_ID_rs2)).

Control outputs are combinational from state and inputs. Priority is freeze > branch > load_use > normal:
- **freeze:** PC_write, IF_ID_write, ID_EX_write and EX_MEM_write are all 0; MEM_WB_bubble=1; both flushes are 0.
- **branch_taken:** all enables are 1; IF_ID_flush=1 and ID_EX_flush=1; MEM_WB_bubble=0. The PC loads the target.
- **load_use (no branch):** PC_write=0 and IF_ID_write=0; ID_EX_flush=1; ID_EX_write=1, EX_MEM_write=1, MEM_WB_bubble=0.
- **normal:** all enables are 1, both flushes are 0, MEM_WB_bubble=0.

A branch that arrives during a freeze is deferred. EX is frozen, so branch_taken stays asserted, and the flush is applied in the first cycle after the freeze ends. It is counted once.

State machine, with a wait counter wcnt of 16 bits:
- **RUN:** if a memory access is pending and dmem_ready=0, go to WAIT with wcnt=1. Otherwise stay.
- **WAIT:**
  - If dmem_ready=1, return to RUN and clear wcnt. The pipeline advances in this same cycle.
  - Else if wcnt == MEM_TIMEOUT, go to ERROR.
  - Else wcnt += 1.
  - If the access request drops while waiting, return to RUN.
- **ERROR:** terminal. mem_err=1 and freeze is held until reset.

Counters:
- stall_cycles increments every cycle in which PC_write=0.
- flush_events increments every cycle in which IF_ID_flush=1.
- Both wrap modulo 2^CNT_W.

## Timing
- Reset (async assert, synchronous-to-clk release): state=RUN, wcnt=0, mem_err=0, stall_cycles=0, flush_events=0.
- Control outputs during reset equal the normal case, unless the inputs force otherwise combinationally.
- Zero-latency control: outputs respond in the same cycle as the inputs.
- Load-use inserts exactly one bubble. On the next cycle the load has moved to MEM, so the hazard clears and forwarding supplies the operand.
- A memory stall lasting N cycles gives N frozen cycles; the pipeline advances on the cycle dmem_ready=1.
- Timeout: with dmem_ready held low, mem_err rises on the edge after MEM_TIMEOUT+1 not-ready cycles.
- Reset asserted mid-WAIT or in ERROR returns to RUN immediately and clears mem_err.
- Register x0 never triggers load_use.

## Test plan
- **Load-use:** `lw x5`, then `add x6,x5,x1`. Required: one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1, then normal; stall_cycles=1.
- **x0 and unused source:** ID_EX_rd=0, or a match only on rs2 with IF_ID_use_rs2=0. Required: no stall; all enables 1.
- **Branch flush:** branch_taken=1 for one cycle. Required: IF_ID_flush=ID_EX_flush=1, PC_write=1; flush_events=1.
- **Branch plus load_use in the same cycle:** required response is the flush only, with PC_write=1 and stall_cycles unchanged.
- **Memory wait, MEM_TIMEOUT=64:** EX_MEM_MemRead=1 and dmem_ready low for 3 cycles. Required: freeze outputs for 3 cycles, advance on the 4th, state back to RUN, stall_cycles=3. Repeat with branch_taken held during the freeze: the flush appears on the release cycle only.
- **Timeout:** MEM_TIMEOUT=4, dmem_ready held 0. Required: mem_err=1 after 5 cycles, freeze held while dmem_ready later goes high. Then pulse rst_n low: mem_err=0, state=RUN, both counters 0.
